// File: rtl/vector_alu_seq_if.sv
// Request/result bus of the sequential vector ALU: one request channel, one result channel.
interface vector_alu_seq_if #(
    parameter int LANES = 5,
    parameter int WIDTH = 32
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid must not wait for ready, and the payload is only looked at on that edge.
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             ALUOp;
    logic                   vv_mode;
    logic [LANES*WIDTH-1:0] va;
    logic [LANES*WIDTH-1:0] vb;
    logic [WIDTH-1:0]       immediate;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] result;
    logic [3:0]             ALUFlags;

    modport master (
        output in_valid, ALUOp, vv_mode, va, vb, immediate, flush, out_ready,
        input  in_ready, out_valid, result, ALUFlags
    );

    modport slave (
        input  in_valid, ALUOp, vv_mode, va, vb, immediate, flush, out_ready,
        output in_ready, out_valid, result, ALUFlags
    );
endinterface

// File: rtl/vector_alu_seq.sv
// Sequential vector ALU: captures a request, evaluates one lane per cycle, then holds
// the result vector and aggregate NZCV flags until the consumer takes them.
module vector_alu_seq #(
    parameter int LANES = 5,
    parameter int WIDTH = 32,
    parameter int IDXW  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    vector_alu_seq_if.slave    bus,
    output logic [1:0]         o_dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a   [LANES];
    logic [WIDTH-1:0] r_b   [LANES];
    logic [WIDTH-1:0] r_res [LANES];
    logic [WIDTH-1:0] w_va  [LANES];
    logic [WIDTH-1:0] w_vb  [LANES];
    logic [2:0]       r_op;
    logic [IDXW-1:0]  r_idx;
    logic [3:0]       r_acc;
    logic [3:0]       r_flags;
    logic             w_in_ready, w_out_valid, w_accept, w_lane_en, w_last;
    logic [LANES*WIDTH-1:0] w_result;

    always_comb begin
        w_result = '0;
        for (int i = 0; i < LANES; i++) begin
            w_va[i] = bus.va[i*WIDTH +: WIDTH];
            w_vb[i] = bus.vb[i*WIDTH +: WIDTH];
            w_result[i*WIDTH +: WIDTH] = r_res[i];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = w_result;
    assign bus.ALUFlags  = r_flags;
    assign o_dbg_state   = r_state;

    assign w_last    = (r_idx == IDXW'(LANES - 1));
    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_lane_en = (r_state == BUSY) && !bus.flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // flush wins over both handshakes in BUSY and DONE; it is a no-op in IDLE.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = BUSY;
            end
            BUSY: begin
                if (bus.flush)   w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.flush || bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    logic [WIDTH-1:0] w_a, w_b, w_bop, w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_sub, w_c, w_v, w_n, w_z;
    logic [3:0]       w_acc_next;

    // SUB reuses the adder as a + ~b + 1, so carry and overflow come out the same way.
    always_comb begin
        w_a   = r_a[r_idx];
        w_b   = r_b[r_idx];
        w_sub = (r_op == 3'b001);
        w_bop = w_sub ? ~w_b : w_b;
        w_sum = {1'b0, w_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            3'b000, 3'b001: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            3'b010:  w_res = w_a & w_b;
            3'b011:  w_res = w_a | w_b;
            3'b100:  w_res = w_a ^ w_b;
            3'b101:  w_res = w_a << w_b[4:0];
            3'b110:  w_res = w_a >> w_b[4:0];
            default: w_res = w_b;
        endcase
        w_n        = w_res[WIDTH-1];
        w_z        = (w_res == '0);
        w_acc_next = {r_acc[3] | w_n, r_acc[2] & w_z, r_acc[1] | w_c, r_acc[0] | w_v};
    end

    // Flags are accumulated privately and published only with the final lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_flags <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_res[i] <= '0;
            end
        end else if (w_accept) begin
            r_op  <= bus.ALUOp;
            r_idx <= '0;
            r_acc <= 4'b0100;
            for (int i = 0; i < LANES; i++) begin
                r_a[i] <= w_va[i];
                r_b[i] <= bus.vv_mode ? w_vb[i] : bus.immediate;
            end
        end else if (w_lane_en) begin
            r_res[r_idx] <= w_res;
            if (w_last) begin
                r_flags <= w_acc_next;
                r_idx   <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + 1'b1;
            end
        end else if (r_state != IDLE && bus.flush) begin
            r_idx <= '0;
        end
    end
endmodule
